// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - RISC240 memory-side responder: word RAM plus an 8-byte MMIO page
//
// Ports:
//   clock, reset_L     system clock (posedge), asynchronous active-low reset
//   re, we             read / write strobes from the control FSM
//   addr               byte address from MAR (bit0 ignored for selection, flags misalign)
//   wrData             write data from MDR
//   sw_in              asynchronous board switches (two-flop synchronized)
//   rdData             registered read data, valid one edge after the re cycle
//   led_out            LED register
//   err_irq            OR of the sticky status bits
module mem_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wrData,
    input  logic [15:0] sw_in,
    output logic [15:0] rdData,
    output logic [15:0] led_out,
    output logic        err_irq
);

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [16:0] RAM_BYTES = 17'(2 * MEM_WORDS);

    logic [15:0] mem [MEM_WORDS];

    logic [15:0] timer;
    logic [2:0]  status;
    logic [15:0] sw_meta;
    logic [15:0] sw_sync;

    logic [15:0]      aligned;
    logic [IDX_W-1:0] ram_idx;
    logic             sel_ram;
    logic             sel_sw;
    logic             sel_led;
    logic             sel_timer;
    logic             sel_status;
    logic             unmapped;
    logic             access;
    logic             conflict;
    logic [15:0]      rd_src;
    logic [2:0]       status_set;
    logic [2:0]       status_clr;

    assign aligned    = {addr[15:1], 1'b0};
    assign ram_idx    = aligned[IDX_W:1];
    assign sel_ram    = ({1'b0, aligned} < RAM_BYTES);
    assign sel_sw     = !sel_ram && (aligned == MMIO_BASE);
    assign sel_led    = !sel_ram && (aligned == MMIO_BASE + 16'd2);
    assign sel_timer  = !sel_ram && (aligned == MMIO_BASE + 16'd4);
    assign sel_status = !sel_ram && (aligned == MMIO_BASE + 16'd6);
    assign unmapped   = !(sel_ram || sel_sw || sel_led || sel_timer || sel_status);
    assign access     = re || we;
    assign conflict   = re && we;

    // Read source mux; only feeds the rdData register, never the output directly.
    always_comb begin
        rd_src = 16'h0000;
        if (sel_ram) begin
            rd_src = mem[ram_idx];
        end else if (sel_sw) begin
            rd_src = sw_sync;
        end else if (sel_led) begin
            rd_src = led_out;
        end else if (sel_timer) begin
            rd_src = timer;
        end else if (sel_status) begin
            rd_src = {13'd0, status};
        end
    end

    // New error events are ORed in after the write-1-to-clear so a set on the
    // same edge as a clear survives.
    always_comb begin
        status_set = {access && unmapped, conflict, access && addr[0]};
        status_clr = 3'b000;
        if (we && sel_status) begin
            status_clr = wrData[2:0];
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            rdData  <= 16'h0000;
            led_out <= 16'h0000;
            timer   <= 16'h0000;
            status  <= 3'b000;
            sw_meta <= 16'h0000;
            sw_sync <= 16'h0000;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            status  <= (status & ~status_clr) | status_set;

            // A simultaneous write wins and the read is dropped.
            if (re && !we) begin
                rdData <= rd_src;
            end

            if (we && sel_led) begin
                led_out <= wrData;
            end

            // A load replaces the increment on that edge.
            if (we && sel_timer) begin
                timer <= wrData;
            end else begin
                timer <= timer + 16'd1;
            end
        end
    end

    // RAM contents survive reset, but an edge seen while reset is held never writes.
    always_ff @(posedge clock or negedge reset_L) begin
        if (reset_L) begin
            if (we && sel_ram) begin
                mem[ram_idx] <= wrData;
            end
        end
    end

    assign err_irq = |status;

endmodule
